// File: rtl/rr_grant_pkg.sv
// Shared types, defaults and helpers for the round-robin grant encoder.
package rr_grant_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_DEF        = 4;
    localparam int MAX_HOLD_DEF = 8;

    // Rotate the low n bits of v left by amt (amt in 0..n); bits at n and above come back zero.
    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n,
                                         input int unsigned amt);
        logic [31:0] r;
        int unsigned j;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            j = i + amt;
            if (j >= n) j = j - n;
            if (i < n) r[j[4:0]] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_grant_encoder_onehot_to_bin.sv
// Combinational one-hot to binary encoder; a zero input encodes to 0.
module onehot_to_bin #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_onehot,
    output logic [W-1:0] o_bin
);

    always_comb begin
        o_bin = '0;
        for (int i = 0; i < N; i++) begin
            if (i_onehot[i]) o_bin = o_bin | W'(i);
        end
    end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter: registers a one-hot grant plus its binary index and
// holds it until done, requester withdrawal, or a MAX_HOLD timeout.
module rr_grant_encoder
    import rr_grant_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    localparam int W       = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic         grant_valid,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         timeout,
    output state_t       dbg_state
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    state_t         r_state,       w_state_nxt;
    logic [N-1:0]   r_grant,       w_grant_nxt;
    logic [W-1:0]   r_grant_idx,   w_grant_idx_nxt;
    logic           r_grant_valid, w_grant_valid_nxt;
    logic           r_timeout,     w_timeout_nxt;
    logic [CW-1:0]  r_hold_cnt,    w_hold_cnt_nxt;
    logic [W-1:0]   r_last,        w_last_nxt;

    logic [W-1:0]   w_start;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_pick;
    logic [N-1:0]   w_next_grant;
    logic [W-1:0]   w_next_idx;
    logic           w_hold_end;
    logic           w_withdraw;

    // Rotate so the requester after the last winner sits at bit 0, take the
    // lowest set bit, then rotate back into requester numbering.
    assign w_start      = (r_last == W'(N - 1)) ? '0 : r_last + W'(1);
    assign w_rot        = N'(rotl(32'(req), N, N - int'(w_start)));
    assign w_pick       = w_rot & (~w_rot + N'(1));
    assign w_next_grant = N'(rotl(32'(w_pick), N, int'(w_start)));

    onehot_to_bin #(.N(N), .W(W)) u_enc (
        .i_onehot (w_next_grant),
        .o_bin    (w_next_idx)
    );

    assign w_hold_end = (r_hold_cnt == CW'(MAX_HOLD - 1));
    assign w_withdraw = ~req[r_grant_idx];

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_grant_idx_nxt   = r_grant_idx;
        w_grant_valid_nxt = r_grant_valid;
        w_timeout_nxt     = 1'b0;
        w_hold_cnt_nxt    = r_hold_cnt;
        w_last_nxt        = r_last;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt       = GRANT;
                    w_grant_nxt       = w_next_grant;
                    w_grant_idx_nxt   = w_next_idx;
                    w_grant_valid_nxt = 1'b1;
                    w_last_nxt        = w_next_idx;
                    w_hold_cnt_nxt    = '0;
                end
            end
            GRANT: begin
                if (done || w_withdraw || w_hold_end) begin
                    w_state_nxt       = IDLE;
                    w_grant_nxt       = '0;
                    w_grant_valid_nxt = 1'b0;
                    // A timeout coinciding with a normal release is not reported.
                    w_timeout_nxt     = w_hold_end && !done && !w_withdraw;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt       = IDLE;
                w_grant_nxt       = '0;
                w_grant_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_hold_cnt    <= '0;
            r_last        <= W'(N - 1);
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_idx   <= w_grant_idx_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_timeout     <= w_timeout_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_last        <= w_last_nxt;
        end
    end

    assign grant_valid = r_grant_valid;
    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign timeout     = r_timeout;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder with an integer-level arbitration model
// checked every cycle, plus hand-computed expectations for each scenario.
module tb_rr_grant_encoder;
    import rr_grant_pkg::*;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int W        = $clog2(N);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         done = 1'b0;
    logic         grant_valid;
    logic [N-1:0] grant;
    logic [W-1:0] grant_idx;
    logic         timeout;
    state_t       dbg_state;

    int total = 0;
    int bad   = 0;

    rr_grant_encoder #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant_valid (grant_valid),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .timeout     (timeout),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- model: winner search by walking requester numbers ----
    bit m_valid   = 1'b0;
    int m_idx     = 0;
    int m_last    = N - 1;
    int m_hold    = 0;
    bit m_timeout = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid   = 1'b0;
            m_idx     = 0;
            m_last    = N - 1;
            m_hold    = 0;
            m_timeout = 1'b0;
        end else begin
            m_timeout = 1'b0;
            if (!m_valid) begin
                if (req != '0) begin
                    bit found;
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        int c;
                        c = (m_last + k) % N;
                        if (!found && req[c]) begin
                            found = 1'b1;
                            m_idx = c;
                        end
                    end
                    m_valid = 1'b1;
                    m_last  = m_idx;
                    m_hold  = 0;
                end
            end else begin
                if (done || !req[m_idx]) begin
                    m_valid = 1'b0;
                end else if (m_hold == MAX_HOLD - 1) begin
                    m_valid   = 1'b0;
                    m_timeout = 1'b1;
                end else begin
                    m_hold = m_hold + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] exp_grant;
        exp_grant = m_valid ? N'(1 << m_idx) : '0;
        check("model grant_valid", 32'(grant_valid), 32'(m_valid));
        check("model grant",       32'(grant),       32'(exp_grant));
        check("model grant_idx",   32'(grant_idx),   32'(m_idx));
        check("model timeout",     32'(timeout),     32'(m_timeout));
        check("model state",       32'(dbg_state),   32'(m_valid ? GRANT : IDLE));
    end

    // ---------------- drivers -------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int to_cnt;
        int exp_seq[5];
        exp_seq = '{0, 1, 2, 3, 0};

        // Reset state
        do_reset();
        check("reset valid", 32'(grant_valid), 32'd0);
        check("reset grant", 32'(grant), 32'd0);
        check("reset idx",   32'(grant_idx), 32'd0);

        // 1: alternate between requesters 0 and 2
        req = 4'b0101;
        tick();
        check("t1 grant0", 32'(grant), 32'b0001);
        check("t1 idx0",   32'(grant_idx), 32'd0);
        pulse_done();
        check("t1 idle gap", 32'(grant_valid), 32'd0);
        tick();
        check("t1 grant2", 32'(grant), 32'b0100);
        check("t1 idx2",   32'(grant_idx), 32'd2);
        pulse_done();
        check("t1 idle gap2", 32'(grant_valid), 32'd0);
        tick();
        check("t1 grant0 again", 32'(grant), 32'b0001);

        // 2: sole requester never releases -> timeout after MAX_HOLD cycles
        do_reset();
        req = 4'b1000;
        tick();
        check("t2 grant3", 32'(grant), 32'b1000);
        cnt = 0;
        to_cnt = 0;
        for (int i = 0; i < 20 && grant_valid; i++) begin
            cnt++;
            tick();
            if (timeout) to_cnt++;
        end
        check("t2 hold cycles", 32'(cnt), 32'd8);
        check("t2 timeout pulses", 32'(to_cnt), 32'd1);
        tick();
        check("t2 timeout cleared", 32'(timeout), 32'd0);
        check("t2 regrant", 32'(grant), 32'b1000);

        // 3: full rotation with wrap
        do_reset();
        req = 4'b1111;
        tick();
        for (int j = 0; j < 5; j++) begin
            check("t3 idx seq", 32'(grant_idx), 32'(exp_seq[j]));
            check("t3 grant seq", 32'(grant), 32'(1 << exp_seq[j]));
            pulse_done();
            tick();
        end

        // 4: requester withdraws mid-hold
        do_reset();
        req = 4'b0010;
        tick();
        check("t4 grant1", 32'(grant), 32'b0010);
        tick();
        tick();
        req = 4'b0000;
        tick();
        check("t4 released", 32'(grant_valid), 32'd0);
        check("t4 no timeout", 32'(timeout), 32'd0);
        check("t4 idle state", 32'(dbg_state), 32'(IDLE));

        // 5: done coinciding with the timeout cycle, then done while idle
        do_reset();
        req = 4'b0001;
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("t5 still held", 32'(grant_valid), 32'd1);
        pulse_done();
        check("t5 released", 32'(grant_valid), 32'd0);
        check("t5 timeout suppressed", 32'(timeout), 32'd0);
        req = 4'b0000;
        tick();
        tick();
        pulse_done();
        check("t5 idle done valid", 32'(grant_valid), 32'd0);
        check("t5 idle done grant", 32'(grant), 32'd0);
        check("t5 idle done timeout", 32'(timeout), 32'd0);

        // 6: asynchronous reset mid-grant, then pointer restarts at requester 0
        do_reset();
        req = 4'b0110;
        tick();
        check("t6 grant1", 32'(grant), 32'b0010);
        #2;
        rst = 1'b1;
        #1;
        check("t6 async valid", 32'(grant_valid), 32'd0);
        check("t6 async grant", 32'(grant), 32'd0);
        check("t6 async idx",   32'(grant_idx), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t6 first after reset", 32'(grant), 32'b0010);
        pulse_done();
        tick();
        check("t6 next rotates", 32'(grant), 32'b0100);

        req = '0;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
